// File: rtl/alu_pkg.sv
// Op codes, select-field layout and FSM state encoding shared by alu_mdu and alu_mdu_iter.
// The multiply/divide datapath is only built when ALU_MDU_M_EN is defined.
package alu_pkg;

    // in_select = {funct7[0], funct3[2:0], funct7[5]}
    localparam int unsigned SEL_M_BIT   = 4;
    localparam int unsigned SEL_F3_MSB  = 3;
    localparam int unsigned SEL_F3_LSB  = 1;
    localparam int unsigned SEL_ALT_BIT = 0;

    // Base ops, indexed by {funct3, funct7[5]}
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1110;

    // M ops, indexed by funct3
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StDone = 2'd2;

endpackage

// File: rtl/alu_mdu_iter.sv
// XLEN-cycle shift-add multiplier and restoring divider sharing one register set.
// Operates on magnitudes; the sign is re-applied to the final result.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  acc_q, lo_q, opb_q;
    logic [2:0]       f3_q;
    logic             neg_q;

    logic            a_sgn, b_sgn, a_neg, b_neg, neg_d;
    logic [XLEN-1:0] a_abs, b_abs;

    always_comb begin
        a_sgn = (funct3_i == M_MULH) || (funct3_i == M_MULHSU) ||
                (funct3_i == M_DIV)  || (funct3_i == M_REM);
        b_sgn = (funct3_i == M_MULH) || (funct3_i == M_DIV) || (funct3_i == M_REM);
        a_neg = a_sgn && a_i[XLEN-1];
        b_neg = b_sgn && b_i[XLEN-1];
        a_abs = a_neg ? -a_i : a_i;
        b_abs = b_neg ? -b_i : b_i;
        // Remainder takes the dividend's sign; everything else the product of signs
        neg_d = (funct3_i == M_REM) ? a_neg : (a_neg ^ b_neg);
    end

    logic [XLEN:0]     sum, rs, diff;
    logic [XLEN-1:0]   acc_n, lo_n, q_s, r_s;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        rs   = {acc_q, lo_q[XLEN-1]};
        diff = rs - {1'b0, opb_q};
        if (f3_q[2]) begin
            // diff[XLEN] set means the trial subtraction went negative: restore
            acc_n = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
            lo_n  = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_n = sum[XLEN:1];
            lo_n  = {sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {acc_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -lo_n : lo_n;
        r_s    = neg_q ? -acc_n : acc_n;
        case (f3_q)
            M_MUL:                      result_o = prod_s[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU:  result_o = prod_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:              result_o = q_s;
            default:                    result_o = r_s;
        endcase
    end

    assign done_o = active_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= a_abs;
            opb_q    <= b_abs;
            f3_q     <= funct3_i;
            neg_q    <= neg_d;
        end else if (active_q) begin
            acc_q <= acc_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// RV32/64-style integer ALU with optional iterative M extension (enable with ALU_MDU_M_EN).
// Single request in flight; result held in DONE until the consumer takes it.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic            in_req_valid,
    output logic            out_req_ready,
    input  logic [XLEN-1:0] in_data1,
    input  logic [XLEN-1:0] in_data2,
    input  logic [4:0]      in_select,
    output logic            out_rsp_valid,
    input  logic            in_rsp_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_busy
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] base_res;
    logic [3:0]      base_op;
    logic [SHAMT_W-1:0] shamt;

    assign base_op = in_select[SEL_F3_MSB:SEL_ALT_BIT];
    assign shamt   = in_data2[SHAMT_W-1:0];

    always_comb begin
        base_res = '0;
        case (base_op)
            OP_ADD:  base_res = in_data1 + in_data2;
            OP_SUB:  base_res = in_data1 - in_data2;
            OP_XOR:  base_res = in_data1 ^ in_data2;
            OP_OR:   base_res = in_data1 | in_data2;
            OP_AND:  base_res = in_data1 & in_data2;
            OP_SLL:  base_res = in_data1 << shamt;
            OP_SRL:  base_res = in_data1 >> shamt;
            OP_SRA:  base_res = $signed(in_data1) >>> shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_data1) < $signed(in_data2)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, in_data1 < in_data2};
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MDU_M_EN
    logic [2:0]      m_f3;
    logic            div_zero, div_ovf, m_special_hit;
    logic [XLEN-1:0] m_special, iter_result;
    logic            iter_start, iter_done;

    assign m_f3 = in_select[SEL_F3_MSB:SEL_F3_LSB];

    // Divide-by-zero and signed overflow finish in one cycle without iterating
    always_comb begin
        div_zero      = (in_data2 == '0);
        div_ovf       = !m_f3[0] && (in_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_data2 == '1);
        m_special_hit = m_f3[2] && (div_zero || div_ovf);
        if (div_zero) begin
            m_special = m_f3[1] ? in_data1 : '1;
        end else begin
            m_special = m_f3[1] ? '0 : in_data1;
        end
    end

    alu_mdu_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk_i    (in_clk),
        .rst_ni   (in_rst_n),
        .start_i  (iter_start),
        .funct3_i (m_f3),
        .a_i      (in_data1),
        .b_i      (in_data2),
        .done_o   (iter_done),
        .result_o (iter_result)
    );
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifdef ALU_MDU_M_EN
        iter_start = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (in_req_valid) begin
                    state_d = StDone;
                    if (!in_select[SEL_M_BIT]) begin
                        data_d = base_res;
                    end else begin
`ifdef ALU_MDU_M_EN
                        if (m_special_hit) begin
                            data_d = m_special;
                        end else begin
                            iter_start = 1'b1;
                            state_d    = StBusy;
                        end
`else
                        data_d = '0;
`endif
                    end
                end
            end
`ifdef ALU_MDU_M_EN
            StBusy: begin
                if (iter_done) begin
                    data_d  = iter_result;
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (in_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_req_ready = (state_q == StIdle);
    assign out_rsp_valid = (state_q == StDone);
    assign out_data      = data_q;
`ifdef ALU_MDU_M_EN
    assign out_busy = (state_q == StBusy);
`else
    assign out_busy = 1'b0;
`endif

endmodule
